// File: rtl/hazard_ctrl_pipe.sv
// Control-word pipeline (ID/EX, EX/MEM, MEM/WB) with load-use/redirect hazard unit and forwarding.
// Optional feature macro: HAZARD_CTRL_FORWARD_EN (EX operand forwarding; otherwise stall-only).
module hazard_ctrl_pipe #(
    parameter int unsigned CTRL_W = 16,
    parameter int unsigned RA_W   = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              hold,
    input  logic              id_valid,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_regwrite,
    input  logic              id_load,
    input  logic [RA_W-1:0]   id_rd,
    input  logic [RA_W-1:0]   id_rs1,
    input  logic [RA_W-1:0]   id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              ex_redirect,
    output logic              stall,
    output logic              flush,
    output logic              ex_valid,
    output logic              mem_valid,
    output logic              wb_valid,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [CTRL_W-1:0] mem_ctrl,
    output logic [CTRL_W-1:0] wb_ctrl,
    output logic [RA_W-1:0]   mem_rd,
    output logic [RA_W-1:0]   wb_rd,
    output logic              wb_regwrite,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic              ex_v_q, ex_rw_q, ex_ld_q, ex_u1_q, ex_u2_q;
    logic [CTRL_W-1:0] ex_ctrl_q;
    logic [RA_W-1:0]   ex_rd_q, ex_rs1_q, ex_rs2_q;
    logic              mem_v_q, mem_rw_q, mem_ld_q;
    logic [CTRL_W-1:0] mem_ctrl_q;
    logic [RA_W-1:0]   mem_rd_q;
    logic              wb_v_q, wb_rw_q;
    logic [CTRL_W-1:0] wb_ctrl_q;
    logic [RA_W-1:0]   wb_rd_q;
    logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;

    logic ex_wr, mem_wr, wb_wr;
    logic id_dep_ex, hazard, bubble;

    // x0 is never a producer
    assign ex_wr  = ex_v_q & ex_rw_q & (ex_rd_q != '0);
    assign mem_wr = mem_v_q & mem_rw_q & (mem_rd_q != '0);
    assign wb_wr  = wb_v_q & wb_rw_q & (wb_rd_q != '0);

    assign id_dep_ex = (id_use_rs1 & (id_rs1 == ex_rd_q)) | (id_use_rs2 & (id_rs2 == ex_rd_q));

`ifdef HAZARD_CTRL_FORWARD_EN
    assign hazard = id_valid & ex_wr & ex_ld_q & id_dep_ex;

    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (ex_v_q) begin
            if (ex_u1_q & mem_wr & ~mem_ld_q & (mem_rd_q == ex_rs1_q)) begin
                fwd_a = 2'b01;
            end else if (wb_wr & (wb_rd_q == ex_rs1_q)) begin
                fwd_a = 2'b10;
            end
            if (ex_u2_q & mem_wr & ~mem_ld_q & (mem_rd_q == ex_rs2_q)) begin
                fwd_b = 2'b01;
            end else if (wb_wr & (wb_rd_q == ex_rs2_q)) begin
                fwd_b = 2'b10;
            end
        end
    end
`else
    logic id_dep_mem;
    logic unused_fwd_state;

    // Without forwarding, any producer in EX or MEM must reach WB before the consumer reads
    assign id_dep_mem = (id_use_rs1 & (id_rs1 == mem_rd_q)) |
                        (id_use_rs2 & (id_rs2 == mem_rd_q));
    assign hazard     = id_valid & ((ex_wr & id_dep_ex) | (mem_wr & id_dep_mem));
    assign fwd_a      = 2'b00;
    assign fwd_b      = 2'b00;
    assign unused_fwd_state = ^{ex_u1_q, ex_u2_q, ex_rs1_q, ex_rs2_q, ex_ld_q, mem_ld_q};
`endif

    assign stall  = hazard & ~ex_redirect & ~hold;
    assign flush  = ex_redirect & ~hold;
    assign bubble = stall | ex_redirect | ~id_valid;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ex_v_q      <= 1'b0;
            ex_rw_q     <= 1'b0;
            ex_ld_q     <= 1'b0;
            ex_u1_q     <= 1'b0;
            ex_u2_q     <= 1'b0;
            ex_ctrl_q   <= '0;
            ex_rd_q     <= '0;
            ex_rs1_q    <= '0;
            ex_rs2_q    <= '0;
            mem_v_q     <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_ld_q    <= 1'b0;
            mem_ctrl_q  <= '0;
            mem_rd_q    <= '0;
            wb_v_q      <= 1'b0;
            wb_rw_q     <= 1'b0;
            wb_ctrl_q   <= '0;
            wb_rd_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (!hold) begin
            if (bubble) begin
                ex_v_q    <= 1'b0;
                ex_rw_q   <= 1'b0;
                ex_ld_q   <= 1'b0;
                ex_u1_q   <= 1'b0;
                ex_u2_q   <= 1'b0;
                ex_ctrl_q <= '0;
                ex_rd_q   <= '0;
                ex_rs1_q  <= '0;
                ex_rs2_q  <= '0;
            end else begin
                ex_v_q    <= 1'b1;
                ex_rw_q   <= id_regwrite;
                ex_ld_q   <= id_load;
                ex_u1_q   <= id_use_rs1;
                ex_u2_q   <= id_use_rs2;
                ex_ctrl_q <= id_ctrl;
                ex_rd_q   <= id_rd;
                ex_rs1_q  <= id_rs1;
                ex_rs2_q  <= id_rs2;
            end
            mem_v_q    <= ex_v_q;
            mem_rw_q   <= ex_rw_q;
            mem_ld_q   <= ex_ld_q;
            mem_ctrl_q <= ex_ctrl_q;
            mem_rd_q   <= ex_rd_q;
            wb_v_q     <= mem_v_q;
            wb_rw_q    <= mem_rw_q;
            wb_ctrl_q  <= mem_ctrl_q;
            wb_rd_q    <= mem_rd_q;
            if (stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (flush && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign ex_valid    = ex_v_q;
    assign mem_valid   = mem_v_q;
    assign wb_valid    = wb_v_q;
    assign ex_ctrl     = ex_ctrl_q;
    assign mem_ctrl    = mem_ctrl_q;
    assign wb_ctrl     = wb_ctrl_q;
    assign mem_rd      = mem_rd_q;
    assign wb_rd       = wb_rd_q;
    assign wb_regwrite = wb_rw_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// Bench for hazard_ctrl_pipe: directed scenarios plus random stream against a stage-list model.
// A second instance with 4-bit counters exercises counter saturation.
module tb_hazard_ctrl_pipe;

`ifdef HAZARD_CTRL_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn, hold, id_valid, id_regwrite, id_load, id_use_rs1, id_use_rs2, ex_redirect;
    logic [15:0] id_ctrl;
    logic [4:0]  id_rd, id_rs1, id_rs2;

    logic        stall, flush, ex_valid, mem_valid, wb_valid, wb_regwrite;
    logic [15:0] ex_ctrl, mem_ctrl, wb_ctrl;
    logic [4:0]  mem_rd, wb_rd;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] stall_cnt, flush_cnt;

    logic        s_stall, s_flush, s_ex_valid, s_mem_valid, s_wb_valid, s_wb_regwrite;
    logic [15:0] s_ex_ctrl, s_mem_ctrl, s_wb_ctrl;
    logic [4:0]  s_mem_rd, s_wb_rd;
    logic [1:0]  s_fwd_a, s_fwd_b;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    hazard_ctrl_pipe #(.CTRL_W(16), .RA_W(5), .CNT_W(32)) u_dut (
        .clk(clk), .rstn(rstn), .hold(hold), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_regwrite(id_regwrite), .id_load(id_load), .id_rd(id_rd), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_redirect(ex_redirect), .stall(stall), .flush(flush), .ex_valid(ex_valid),
        .mem_valid(mem_valid), .wb_valid(wb_valid), .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl),
        .wb_ctrl(wb_ctrl), .mem_rd(mem_rd), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_ctrl_pipe #(.CTRL_W(16), .RA_W(5), .CNT_W(4)) u_sat (
        .clk(clk), .rstn(rstn), .hold(hold), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_regwrite(id_regwrite), .id_load(id_load), .id_rd(id_rd), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_redirect(ex_redirect), .stall(s_stall), .flush(s_flush), .ex_valid(s_ex_valid),
        .mem_valid(s_mem_valid), .wb_valid(s_wb_valid), .ex_ctrl(s_ex_ctrl),
        .mem_ctrl(s_mem_ctrl), .wb_ctrl(s_wb_ctrl), .mem_rd(s_mem_rd), .wb_rd(s_wb_rd),
        .wb_regwrite(s_wb_regwrite), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: one instruction record per stage, shifted as a list
    typedef struct {
        logic v; logic [15:0] c; logic rw; logic ld;
        logic [4:0] rd; logic [4:0] rs1; logic [4:0] rs2; logic u1; logic u2;
    } ent_t;
    localparam ent_t BUB = '{default: '0};
    ent_t        m_ex = BUB, m_mem = BUB, m_wb = BUB;
    logic [31:0] m_sc = '0, m_fc = '0;

    function automatic ent_t id_ent();
        ent_t e;
        e.v = id_valid; e.c = id_ctrl; e.rw = id_regwrite; e.ld = id_load;
        e.rd = id_rd; e.rs1 = id_rs1; e.rs2 = id_rs2; e.u1 = id_use_rs1; e.u2 = id_use_rs2;
        return e;
    endfunction

    function automatic bit writes(ent_t e);
        return e.v && e.rw && (e.rd != 0);
    endfunction

    function automatic bit reads(ent_t e, logic [4:0] r);
        return (e.u1 && e.rs1 == r) || (e.u2 && e.rs2 == r);
    endfunction

    function automatic bit m_stall();
        ent_t i = id_ent();
        bit   hz;
        if (FWD) hz = i.v && writes(m_ex) && m_ex.ld && reads(i, m_ex.rd);
        else     hz = i.v && ((writes(m_ex) && reads(i, m_ex.rd)) ||
                              (writes(m_mem) && reads(i, m_mem.rd)));
        return hz && !ex_redirect && !hold;
    endfunction

    function automatic bit m_flush();
        return ex_redirect && !hold;
    endfunction

    function automatic logic [1:0] m_fwd(logic use_r, logic [4:0] r);
        if (!FWD || !m_ex.v) return 2'b00;
        if (use_r && writes(m_mem) && !m_mem.ld && m_mem.rd == r) return 2'b01;
        if (writes(m_wb) && m_wb.rd == r) return 2'b10;
        return 2'b00;
    endfunction

    always @(posedge clk) begin
        if (!rstn) begin
            m_ex <= BUB; m_mem <= BUB; m_wb <= BUB; m_sc <= '0; m_fc <= '0;
        end else if (!hold) begin
            m_ex  <= (m_stall() || ex_redirect || !id_valid) ? BUB : id_ent();
            m_mem <= m_ex;
            m_wb  <= m_mem;
            if (m_stall()) m_sc <= m_sc + 1;
            if (m_flush()) m_fc <= m_fc + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(logic v, logic rw, logic ld, logic [4:0] rd, logic [4:0] rs1,
                          logic [4:0] rs2, logic u1, logic u2);
        id_valid = v; id_regwrite = rw; id_load = ld; id_rd = rd;
        id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        id_ctrl = 16'($urandom);
    endtask

    task automatic nop();
        set_id(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    // Let the current ID instruction wait out any stall, then move it into EX
    task automatic issue();
        hold = 1'b0; ex_redirect = 1'b0;
        for (int k = 0; k < 4 && m_stall(); k++) tick();
        if (m_stall()) begin
            n_cmp++; n_bad++;
            $display("FAIL issue_timeout: got stall still high want stall released");
        end
        tick();
    endtask

    task automatic do_reset();
        rstn = 1'b0; hold = 1'b0; ex_redirect = 1'b0;
        nop();
        tick(); tick();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; hold = 1'b1; ex_redirect = 1'b0;
        set_id(1'b1, 1'b1, 1'b0, 5'd3, 5'd1, 5'd2, 1'b1, 1'b1);
        tick(); tick();
        hold = 1'b0; nop(); #1;
        n_cmp++; if ({ex_valid, mem_valid, wb_valid} !== 3'b000) begin n_bad++;
            $display("FAIL reset_valid: got %b want 000", {ex_valid, mem_valid, wb_valid}); end
        n_cmp++; if ({ex_ctrl, mem_ctrl, wb_ctrl, mem_rd, wb_rd, wb_regwrite} !== '0) begin n_bad++;
            $display("FAIL reset_fields: got %h want 0", {ex_ctrl, mem_ctrl, wb_ctrl, mem_rd, wb_rd}); end
        n_cmp++; if ({stall, flush, fwd_a, fwd_b} !== 6'b0) begin n_bad++;
            $display("FAIL reset_comb: got %b want 0", {stall, flush, fwd_a, fwd_b}); end
        n_cmp++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin n_bad++;
            $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
        rstn = 1'b1;
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(1'b1, 1'b1, 1'b1, 5'd5, 5'd2, 5'd0, 1'b1, 1'b0);   // lw x5
        issue();
        set_id(1'b1, 1'b1, 1'b0, 5'd6, 5'd5, 5'd1, 1'b1, 1'b1);   // add x6,x5,x1
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_bad++;
            $display("FAIL lu_stall: got %b want 1", stall); end
        tick();
        n_cmp++; if (ex_valid !== 1'b0 || stall_cnt !== 32'd1) begin n_bad++;
            $display("FAIL lu_bubble: got ex_valid=%b cnt=%0d want 0/1", ex_valid, stall_cnt); end
        n_cmp++; if (stall !== !FWD) begin n_bad++;
            $display("FAIL lu_stall2: got %b want %b", stall, !FWD); end
        issue();
        nop(); #1;
        n_cmp++; if (fwd_a !== (FWD ? 2'b10 : 2'b00) || fwd_b !== 2'b00) begin n_bad++;
            $display("FAIL lu_fwd: got %b/%b want %b/00", fwd_a, fwd_b, FWD ? 2'b10 : 2'b00); end
        n_cmp++; if (stall_cnt !== (FWD ? 32'd1 : 32'd2) || ex_valid !== 1'b1) begin n_bad++;
            $display("FAIL lu_cnt: got %0d ex_valid=%b", stall_cnt, ex_valid); end
    endtask

    task automatic test_forward();
        do_reset();
        set_id(1'b1, 1'b1, 1'b0, 5'd5, 5'd1, 5'd2, 1'b1, 1'b1);   // add x5
        issue();
        set_id(1'b1, 1'b1, 1'b0, 5'd7, 5'd5, 5'd5, 1'b1, 1'b1);   // sub x7,x5,x5
        #1;
        n_cmp++; if (stall !== !FWD) begin n_bad++;
            $display("FAIL fw_stall: got %b want %b", stall, !FWD); end
        issue();
        nop(); #1;
        n_cmp++; if (fwd_a !== (FWD ? 2'b01 : 2'b00) || fwd_b !== (FWD ? 2'b01 : 2'b00)) begin
            n_bad++; $display("FAIL fw_sel: got %b/%b", fwd_a, fwd_b); end
        n_cmp++; if (stall_cnt !== (FWD ? 32'd0 : 32'd2)) begin n_bad++;
            $display("FAIL fw_cnt: got %0d want %0d", stall_cnt, FWD ? 0 : 2); end
        do_reset();
        set_id(1'b1, 1'b1, 1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1);   // add x0
        issue();
        set_id(1'b1, 1'b1, 1'b0, 5'd7, 5'd0, 5'd0, 1'b1, 1'b1);
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++;
            $display("FAIL fw_x0_stall: got %b want 0", stall); end
        tick(); nop(); #1;
        n_cmp++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin n_bad++;
            $display("FAIL fw_x0_sel: got %b/%b want 00/00", fwd_a, fwd_b); end
    endtask

    task automatic test_mem_priority();
        do_reset();
        set_id(1'b1, 1'b1, 1'b0, 5'd5, 5'd1, 5'd2, 1'b1, 1'b1);
        issue();
        set_id(1'b1, 1'b1, 1'b0, 5'd5, 5'd3, 5'd2, 1'b1, 1'b1);
        issue();
        set_id(1'b1, 1'b1, 1'b0, 5'd6, 5'd5, 5'd1, 1'b1, 1'b0);
        issue();
        nop(); #1;
        n_cmp++; if (fwd_a !== (FWD ? 2'b01 : 2'b00) || fwd_b !== 2'b00) begin n_bad++;
            $display("FAIL prio_sel: got %b/%b want %b/00", fwd_a, fwd_b, FWD ? 2'b01 : 2'b00); end
    endtask

    task automatic test_redirect();
        do_reset();
        set_id(1'b1, 1'b1, 1'b1, 5'd5, 5'd2, 5'd0, 1'b1, 1'b0);
        issue();
        set_id(1'b1, 1'b1, 1'b0, 5'd6, 5'd5, 5'd1, 1'b1, 1'b1);
        ex_redirect = 1'b1;
        #1;
        n_cmp++; if (stall !== 1'b0 || flush !== 1'b1) begin n_bad++;
            $display("FAIL rd_comb: got stall=%b flush=%b want 0/1", stall, flush); end
        tick();
        ex_redirect = 1'b0; nop(); #1;
        n_cmp++; if (ex_valid !== 1'b0 || mem_valid !== 1'b1) begin n_bad++;
            $display("FAIL rd_bubble: got ex=%b mem=%b want 0/1", ex_valid, mem_valid); end
        n_cmp++; if (flush_cnt !== 32'd1 || stall_cnt !== 32'd0) begin n_bad++;
            $display("FAIL rd_cnt: got %0d/%0d want 1/0", flush_cnt, stall_cnt); end
    endtask

    task automatic test_hold();
        logic [15:0] c_a, c_b, c_l;
        do_reset();
        set_id(1'b1, 1'b1, 1'b0, 5'd3, 5'd1, 5'd2, 1'b1, 1'b0); c_a = id_ctrl; issue();
        set_id(1'b1, 1'b1, 1'b0, 5'd4, 5'd1, 5'd0, 1'b1, 1'b0); c_b = id_ctrl; issue();
        set_id(1'b1, 1'b1, 1'b1, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0); c_l = id_ctrl; issue();
        set_id(1'b1, 1'b1, 1'b0, 5'd6, 5'd5, 5'd0, 1'b1, 1'b0);
        hold = 1'b1; ex_redirect = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if (stall !== 1'b0 || flush !== 1'b0) begin n_bad++;
                $display("FAIL hold_comb%0d: got %b%b want 00", k, stall, flush); end
            tick();
        end
        n_cmp++; if ({ex_ctrl, mem_ctrl, wb_ctrl} !== {c_l, c_b, c_a}) begin n_bad++;
            $display("FAIL hold_ctrl: got %h want %h", {ex_ctrl, mem_ctrl, wb_ctrl}, {c_l, c_b, c_a}); end
        n_cmp++; if ({ex_valid, mem_valid, wb_valid, mem_rd, wb_rd} !== {3'b111, 5'd4, 5'd3}) begin
            n_bad++; $display("FAIL hold_state: got %b %0d %0d", {ex_valid, mem_valid, wb_valid},
                              mem_rd, wb_rd); end
        n_cmp++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin n_bad++;
            $display("FAIL hold_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
        hold = 1'b0; ex_redirect = 1'b0;
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        set_id(1'b1, 1'b1, 1'b0, 5'd5, 5'd1, 5'd2, 1'b1, 1'b1);
        issue();
        set_id(1'b1, 1'b1, 1'b0, 5'd6, 5'd5, 5'd0, 1'b1, 1'b1);   // add x6,x5,x0
        #1;
        n_cmp++; if (stall !== !FWD) begin n_bad++;
            $display("FAIL rms_stall: got %b want %b", stall, !FWD); end
        tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1; #1;
        n_cmp++; if ({ex_valid, mem_valid, wb_valid, stall} !== 4'b0 || stall_cnt !== 32'd0) begin
            n_bad++; $display("FAIL rms_clear: got %b cnt=%0d want 0000/0",
                              {ex_valid, mem_valid, wb_valid, stall}, stall_cnt); end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int p = 0; p < 20; p++) begin
            set_id(1'b1, 1'b1, 1'b1, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0);
            issue();
            set_id(1'b1, 1'b1, 1'b0, 5'd6, 5'd5, 5'd1, 1'b1, 1'b1);
            issue();
        end
        nop(); #1;
        n_cmp++; if (stall_cnt !== (FWD ? 32'd20 : 32'd40)) begin n_bad++;
            $display("FAIL sat_wide: got %0d want %0d", stall_cnt, FWD ? 20 : 40); end
        n_cmp++; if (s_stall_cnt !== 4'hF) begin n_bad++;
            $display("FAIL sat_narrow: got %0d want 15", s_stall_cnt); end
    endtask

    task automatic test_random();
        logic [67:0] act, exp;
        logic [3:0]  exp_sat;
        bit          keep = 1'b0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rstn        = ($urandom_range(0, 99) != 0);
            hold        = ($urandom_range(0, 9) == 0);
            ex_redirect = ($urandom_range(0, 7) == 0);
            if (!keep)
                set_id(1'($urandom_range(0, 99) < 85), 1'($urandom), 1'($urandom_range(0, 2) == 0),
                       5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                       5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
            #1;
            act = {stall, flush, fwd_a, fwd_b, ex_valid, ex_ctrl, mem_valid, mem_ctrl, wb_valid,
                   wb_ctrl, wb_regwrite, mem_valid ? mem_rd : 5'd0, wb_valid ? wb_rd : 5'd0};
            exp = {m_stall(), m_flush(), m_fwd(m_ex.u1, m_ex.rs1), m_fwd(m_ex.u2, m_ex.rs2),
                   m_ex.v, m_ex.c, m_mem.v, m_mem.c, m_wb.v, m_wb.c, m_wb.rw,
                   m_mem.v ? m_mem.rd : 5'd0, m_wb.v ? m_wb.rd : 5'd0};
            n_cmp++; if (act !== exp) begin n_bad++;
                $display("FAIL rand_state%0d: got %h want %h", i, act, exp); end
            exp_sat = (m_sc > 32'd15) ? 4'hF : m_sc[3:0];
            n_cmp++; if (stall_cnt !== m_sc || flush_cnt !== m_fc || s_stall_cnt !== exp_sat) begin
                n_bad++; $display("FAIL rand_cnt%0d: got %0d/%0d/%0d want %0d/%0d/%0d", i,
                                  stall_cnt, flush_cnt, s_stall_cnt, m_sc, m_fc, exp_sat); end
            keep = rstn && (hold || m_stall());
            tick();
        end
    endtask

    initial begin
        rstn = 1'b0; hold = 1'b0; ex_redirect = 1'b0;
        nop();
        test_reset();
        test_load_use();
        test_forward();
        test_mem_priority();
        test_redirect();
        test_hold();
        test_reset_mid_stall();
        test_saturate();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
